// File: rtl/sdram_port_scheduler.sv
// Four-port request scheduler in front of the SDRAM page-burst controller.
// Define SCHED_RR_EN for round-robin selection; the default build uses fixed priority 0>1>2>3.
module sdram_port_scheduler #(
  parameter int ASIZE = 22,
  parameter int LSIZE = 9,
  parameter int USIZE = 16
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [3:0]           P_LOAD,
  input  logic [4*ASIZE-1:0]   P_START,
  input  logic [4*ASIZE-1:0]   P_MAX,
  input  logic [4*LSIZE-1:0]   P_LEN,
  input  logic [4*USIZE-1:0]   P_LEVEL,
  output logic                 CMD_REQ,
  output logic                 CMD_WRITE,
  output logic [ASIZE-1:0]     CMD_ADDR,
  output logic [LSIZE-1:0]     CMD_LEN,
  input  logic                 CMD_ACK,
  input  logic                 CMD_DONE,
  output logic [3:0]           GRANT,
  output logic                 BUSY
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_GAP} state_t;

  state_t             r_state;
  state_t             w_next;

  logic [ASIZE-1:0]   r_start [4];
  logic [ASIZE-1:0]   r_max   [4];
  logic [ASIZE-1:0]   r_ptr   [4];
  logic [LSIZE-1:0]   r_len   [4];

  logic [3:0]         w_elig;
  logic [1:0]         w_sel;
  logic               w_any;

  logic [3:0]         r_grant;
  logic [1:0]         r_gidx;
  logic               r_load_hit;
  logic               r_cmd_write;
  logic [ASIZE-1:0]   r_cmd_addr;
  logic [LSIZE-1:0]   r_cmd_len;

  logic [ASIZE-1:0]   w_len_ext;
  logic [ASIZE-1:0]   w_limit;
  logic [ASIZE-1:0]   w_adv;
  logic               w_take;
  logic               w_done_adv;

  // Ports 0/1 feed read FIFOs (need room), ports 2/3 drain write FIFOs (need data).
  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (r_len[i] != '0 && !P_LOAD[i]) begin
        if (i < 2)
          w_elig[i] = P_LEVEL[i*USIZE +: USIZE] <  USIZE'(r_len[i]);
        else
          w_elig[i] = P_LEVEL[i*USIZE +: USIZE] >= USIZE'(r_len[i]);
      end
    end
  end

`ifdef SCHED_RR_EN
  logic [1:0] r_last;

  always_comb begin
    logic [1:0] v_idx;
    w_sel = '0;
    w_any = 1'b0;
    v_idx = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      v_idx = r_last + 2'(k + 1);
      if (!w_any && w_elig[v_idx]) begin
        w_any = 1'b1;
        w_sel = v_idx;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      r_last <= 2'd3;
    else if (r_state == S_IDLE && w_any)
      r_last <= w_sel;
  end
`else
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!w_any && w_elig[k]) begin
        w_any = 1'b1;
        w_sel = 2'(k);
      end
    end
  end
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any)    w_next = S_REQ;
      S_REQ:   if (CMD_ACK)  w_next = S_WAIT;
      S_WAIT:  if (CMD_DONE) w_next = S_GAP;
      S_GAP:                 w_next = S_IDLE;
      default:               w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Wrap when the next burst would not fit below max, including max < len.
  assign w_len_ext  = ASIZE'(r_len[r_gidx]);
  assign w_limit    = r_max[r_gidx] - w_len_ext;
  assign w_take     = (r_max[r_gidx] >= w_len_ext) && (r_ptr[r_gidx] < w_limit);
  assign w_adv      = w_take ? (r_ptr[r_gidx] + w_len_ext) : r_start[r_gidx];
  assign w_done_adv = (r_state == S_WAIT) && CMD_DONE && !r_load_hit;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_start[i] <= '0;
        r_max[i]   <= '0;
        r_ptr[i]   <= '0;
        r_len[i]   <= '0;
      end
      r_grant     <= '0;
      r_gidx      <= '0;
      r_load_hit  <= 1'b0;
      r_cmd_write <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_len   <= '0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_cmd_addr  <= r_ptr[w_sel];
        r_cmd_len   <= r_len[w_sel];
        r_cmd_write <= w_sel[1];
        r_grant     <= 4'b0001 << w_sel;
        r_gidx      <= w_sel;
        r_load_hit  <= 1'b0;
      end
      if (r_state == S_WAIT && CMD_DONE)
        r_grant <= '0;
      // A reload of the active port while its burst runs cancels the pending advance.
      if (|(P_LOAD & r_grant))
        r_load_hit <= 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
        if (P_LOAD[i]) begin
          r_start[i] <= P_START[i*ASIZE +: ASIZE];
          r_max[i]   <= P_MAX[i*ASIZE +: ASIZE];
          r_len[i]   <= P_LEN[i*LSIZE +: LSIZE];
          r_ptr[i]   <= P_START[i*ASIZE +: ASIZE];
        end else if (w_done_adv && r_gidx == 2'(i)) begin
          r_ptr[i] <= w_adv;
        end
      end
    end
  end

  assign CMD_REQ   = (r_state == S_REQ);
  assign BUSY      = (r_state != S_IDLE);
  assign CMD_WRITE = r_cmd_write;
  assign CMD_ADDR  = r_cmd_addr;
  assign CMD_LEN   = r_cmd_len;
  assign GRANT     = r_grant;

endmodule

// File: tb/tb_sdram_port_scheduler.sv
// Directed bench for sdram_port_scheduler; expectations follow SCHED_RR_EN when defined.
module tb_sdram_port_scheduler;

  localparam int ASIZE = 22;
  localparam int LSIZE = 9;
  localparam int USIZE = 16;

  logic               CLK = 1'b0;
  logic               RESET_N;
  logic [3:0]         P_LOAD;
  logic [4*ASIZE-1:0] P_START;
  logic [4*ASIZE-1:0] P_MAX;
  logic [4*LSIZE-1:0] P_LEN;
  logic [4*USIZE-1:0] P_LEVEL;
  logic               CMD_REQ;
  logic               CMD_WRITE;
  logic [ASIZE-1:0]   CMD_ADDR;
  logic [LSIZE-1:0]   CMD_LEN;
  logic               CMD_ACK;
  logic               CMD_DONE;
  logic [3:0]         GRANT;
  logic               BUSY;

  int n_cmp  = 0;
  int n_fail = 0;

  sdram_port_scheduler #(.ASIZE(ASIZE), .LSIZE(LSIZE), .USIZE(USIZE)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .P_LOAD    (P_LOAD),
    .P_START   (P_START),
    .P_MAX     (P_MAX),
    .P_LEN     (P_LEN),
    .P_LEVEL   (P_LEVEL),
    .CMD_REQ   (CMD_REQ),
    .CMD_WRITE (CMD_WRITE),
    .CMD_ADDR  (CMD_ADDR),
    .CMD_LEN   (CMD_LEN),
    .CMD_ACK   (CMD_ACK),
    .CMD_DONE  (CMD_DONE),
    .GRANT     (GRANT),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input int start, input int max, input int len);
    P_START[p*ASIZE +: ASIZE] = ASIZE'(start);
    P_MAX[p*ASIZE +: ASIZE]   = ASIZE'(max);
    P_LEN[p*LSIZE +: LSIZE]   = LSIZE'(len);
  endtask

  task automatic load_port(input int p, input int start, input int max, input int len);
    set_port(p, start, max, len);
    P_LOAD[p] = 1'b1;
    tick();
    P_LOAD[p] = 1'b0;
  endtask

  task automatic set_level(input int p, input int lvl);
    P_LEVEL[p*USIZE +: USIZE] = USIZE'(lvl);
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!CMD_REQ && n < 50) begin
      tick();
      n++;
    end
    chk($sformatf("%s_req", tag), 32'(CMD_REQ), 32'd1);
  endtask

  task automatic ack_done();
    CMD_ACK = 1'b1;
    tick();
    CMD_ACK = 1'b0;
    tick();
    CMD_DONE = 1'b1;
    tick();
    CMD_DONE = 1'b0;
  endtask

  task automatic burst(input string tag, input int addr, input logic [3:0] gnt);
    wait_req(tag);
    chk($sformatf("%s_addr", tag),  32'(CMD_ADDR), 32'(addr));
    chk($sformatf("%s_grant", tag), 32'(GRANT), 32'(gnt));
    chk($sformatf("%s_write", tag), 32'(CMD_WRITE), 32'(gnt[2] | gnt[3]));
    ack_done();
    chk($sformatf("%s_gclr", tag), 32'(GRANT), 32'd0);
  endtask

  initial begin
    RESET_N  = 1'b0;
    P_LOAD   = '0;
    P_START  = '0;
    P_MAX    = '0;
    P_LEN    = '0;
    P_LEVEL  = '0;
    CMD_ACK  = 1'b0;
    CMD_DONE = 1'b0;
    repeat (2) tick();

    chk("rst_req",   32'(CMD_REQ),   32'd0);
    chk("rst_write", 32'(CMD_WRITE), 32'd0);
    chk("rst_addr",  32'(CMD_ADDR),  32'd0);
    chk("rst_len",   32'(CMD_LEN),   32'd0);
    chk("rst_grant", 32'(GRANT),     32'd0);
    chk("rst_busy",  32'(BUSY),      32'd0);
    RESET_N = 1'b1;
    repeat (3) tick();
    chk("unloaded_idle", 32'(BUSY), 32'd0);

    // Port 2 write: eligibility threshold at level == len.
    load_port(2, 'h100, 'h300, 128);
    repeat (2) tick();
    chk("p2_lvl0", 32'(CMD_REQ), 32'd0);
    set_level(2, 127);
    repeat (2) tick();
    chk("p2_lvl127", 32'(CMD_REQ), 32'd0);
    set_level(2, 128);
    tick();
    chk("p2_req",   32'(CMD_REQ),   32'd1);
    chk("p2_write", 32'(CMD_WRITE), 32'd1);
    chk("p2_addr",  32'(CMD_ADDR),  32'h100);
    chk("p2_len",   32'(CMD_LEN),   32'd128);
    chk("p2_grant", 32'(GRANT),     32'b0100);
    chk("p2_busy",  32'(BUSY),      32'd1);
    CMD_ACK = 1'b1;
    tick();
    CMD_ACK = 1'b0;
    chk("p2_ack_req",   32'(CMD_REQ), 32'd0);
    chk("p2_wait_gnt",  32'(GRANT),   32'b0100);
    tick();
    CMD_DONE = 1'b1;
    tick();
    CMD_DONE = 1'b0;
    chk("p2_gap_gnt",  32'(GRANT), 32'd0);
    chk("p2_gap_busy", 32'(BUSY),  32'd1);
    tick();
    chk("p2_idle_busy", 32'(BUSY),    32'd0);
    chk("p2_idle_req",  32'(CMD_REQ), 32'd0);
    tick();
    chk("p2_k3_req",  32'(CMD_REQ),  32'd1);
    chk("p2_k3_addr", 32'(CMD_ADDR), 32'h180);
    ack_done();
    burst("p2_b3", 'h200, 4'b0100);
    burst("p2_b4", 'h280, 4'b0100);
    burst("p2_wrap", 'h100, 4'b0100);
    set_level(2, 0);
    repeat (3) tick();
    chk("p2_off", 32'(CMD_REQ), 32'd0);

    // Stray handshake pulses while idle.
    CMD_ACK  = 1'b1;
    CMD_DONE = 1'b1;
    tick();
    CMD_ACK  = 1'b0;
    CMD_DONE = 1'b0;
    tick();
    chk("stray_busy", 32'(BUSY), 32'd0);

    // Port 0 read: level == len not eligible; pointer wraps at max.
    set_level(0, 128);
    load_port(0, 0, 256, 128);
    repeat (2) tick();
    chk("p0_lvl_eq_len", 32'(CMD_REQ), 32'd0);
    set_level(0, 0);
    burst("p0_b1", 0,   4'b0001);
    chk("p0_len", 32'(CMD_LEN), 32'd128);
    burst("p0_b2", 128, 4'b0001);
    burst("p0_b3", 0,   4'b0001);
    load_port(0, 0, 256, 0);
    repeat (3) tick();
    chk("p0_off", 32'(CMD_REQ), 32'd0);

    // Port 1 reloaded while its burst is in WAIT; then load coincident with DONE.
    load_port(1, 'h10, 'h1000, 16);
    burst("p1_b1_pre", 'h10, 4'b0010);
    wait_req("p1_b2");
    chk("p1_b2_addr", 32'(CMD_ADDR), 32'h20);
    CMD_ACK = 1'b1;
    tick();
    CMD_ACK = 1'b0;
    tick();
    load_port(1, 'h40, 'h1000, 16);
    chk("p1_load_gnt", 32'(GRANT), 32'b0010);
    CMD_DONE = 1'b1;
    tick();
    CMD_DONE = 1'b0;
    chk("p1_done_gclr", 32'(GRANT), 32'd0);
    burst("p1_reload", 'h40, 4'b0010);
    wait_req("p1_adv");
    chk("p1_adv_addr", 32'(CMD_ADDR), 32'h50);
    CMD_ACK = 1'b1;
    tick();
    CMD_ACK = 1'b0;
    tick();
    set_port(1, 'h60, 'h1000, 16);
    P_LOAD[1] = 1'b1;
    CMD_DONE  = 1'b1;
    tick();
    P_LOAD[1] = 1'b0;
    CMD_DONE  = 1'b0;
    burst("p1_ld_done", 'h60, 4'b0010);
    load_port(1, 0, 0, 0);
    repeat (3) tick();
    chk("p1_off", 32'(CMD_REQ), 32'd0);

    // Port 3 write, then asynchronous reset while in WAIT.
    set_level(3, 50);
    load_port(3, 'h20, 'h100, 8);
    wait_req("p3");
    chk("p3_addr",  32'(CMD_ADDR), 32'h20);
    chk("p3_grant", 32'(GRANT),    32'b1000);
    CMD_ACK = 1'b1;
    tick();
    CMD_ACK = 1'b0;
    chk("p3_wait_busy", 32'(BUSY), 32'd1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("arst_req",   32'(CMD_REQ),  32'd0);
    chk("arst_grant", 32'(GRANT),    32'd0);
    chk("arst_busy",  32'(BUSY),     32'd0);
    chk("arst_addr",  32'(CMD_ADDR), 32'd0);
    tick();
    RESET_N = 1'b1;
    set_level(0, 0);
    set_level(1, 0);
    set_level(2, 'hFFFF);
    set_level(3, 'hFFFF);
    repeat (10) tick();
    chk("post_rst_noreq", 32'(BUSY), 32'd0);

    // len = 0 never granted, at any level.
    load_port(0, 5, 'h100, 0);
    repeat (5) tick();
    chk("len0_lo", 32'(BUSY), 32'd0);
    set_level(0, 'hFFFF);
    repeat (5) tick();
    chk("len0_hi", 32'(BUSY), 32'd0);
    set_level(0, 0);

    // All four ports continuously eligible.
    P_START = {22'hC00, 22'h800, 22'h400, 22'h000};
    P_MAX   = {4{22'h1000}};
    P_LEN   = {4{9'd4}};
    P_LOAD  = 4'hF;
    tick();
    P_LOAD  = 4'h0;
    for (int j = 0; j < 8; j++) begin
`ifdef SCHED_RR_EN
      burst($sformatf("all_%0d", j), (j % 4) * 'h400 + (j / 4) * 4, 4'b0001 << (j % 4));
`else
      burst($sformatf("all_%0d", j), j * 4, 4'b0001);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_port_scheduler.md
# sdram_port_scheduler

Four-port request scheduler that shares the single-transaction SDRAM page-burst controller between two read-side FIFOs (ports 0, 1) and two write-side FIFOs (ports 2, 3). It sits between the port FIFOs and the burst controller's command interface. It watches FIFO fill levels, picks one eligible port, and issues a start address, length and direction with a req/ack handshake. On completion it advances that port's address pointer with wrap-around.

## Interface
- ASIZE, 22, SDRAM word-address width
- LSIZE, 9, burst-length width
- USIZE, 16, FIFO used-words width
- CLK  in  1  controller clock
- RESET_N  in  1  asynchronous, active-low reset
- P_LOAD  in  4  per-port load strobe: latch START/MAX/LEN, reset pointer
- P_START  in  4*ASIZE  per-port start address; port i at [i*ASIZE +: ASIZE]
- P_MAX  in  4*ASIZE  per-port end address (exclusive)
- P_LEN  in  4*LSIZE  per-port burst length
- P_LEVEL  in  4*USIZE  ports 0/1: read-FIFO write-side usedw; ports 2/3: write-FIFO read-side usedw
- CMD_REQ  out  1  transaction request to burst controller
- CMD_WRITE  out  1  1 = write burst, 0 = read burst
- CMD_ADDR  out  ASIZE  burst start address
- CMD_LEN  out  LSIZE  burst length
- CMD_ACK  in  1  controller accepted request (1-cycle pulse)
- CMD_DONE  in  1  burst finished (1-cycle pulse)
- GRANT  out  4  one-hot active port; steers FIFO rdreq/wrreq muxing
- BUSY  out  1  high in any state other than IDLE

## Operation
- Per-port registers: start, max, len and ptr. All reset to 0, so nothing is eligible until a port is loaded.
- Eligibility for a read port i: len≠0 and level < len.
- Eligibility for a write port i: len≠0 and level ≥ len.
- A port whose P_LOAD is high in the current cycle is never eligible.
- The state machine has four states: IDLE, REQ, WAIT and GAP.
- IDLE:
  - If any port is eligible, register the winner's ptr, len and direction onto CMD_*, set GRANT, go to REQ.
  - Otherwise stay.
- REQ:
  - CMD_REQ=1.
  - On CMD_ACK, drop CMD_REQ and go to WAIT.
- WAIT:
  - On CMD_DONE, advance the granted port's ptr, clear GRANT, go to GAP.
- GAP: one idle cycle so FIFO levels can settle, then go to IDLE.
- Pointer advance: if ptr < max − len, ptr ← ptr + len; else ptr ← start.
  - Arithmetic is unsigned at ASIZE bits; len is zero-extended.
  - The max − len underflow case (max < len) always wraps to start.
- Load:
  - P_LOAD[i] sets ptr ← P_START and latches start, max and len in any state.
  - If port i is granted when its load occurs, the transfer runs to completion. The CMD_DONE advance for that port is suppressed and the load value wins.
  - If load and done occur in the same cycle, load wins.
- CMD_ADDR, CMD_LEN and CMD_WRITE are held stable from entry to REQ until the next IDLE selection.
- Stray CMD_ACK outside REQ and stray CMD_DONE outside WAIT are ignored.

## Timing
- Reset values: CMD_REQ=0, CMD_WRITE=0, CMD_ADDR=0, CMD_LEN=0, GRANT=0, BUSY=0, state=IDLE, round-robin last-grant=3.
- An eligible port seen in IDLE at cycle n gives GRANT and CMD_* valid and CMD_REQ=1 at n+1.
- CMD_ACK at cycle m gives CMD_REQ=0 at m+1.
- CMD_DONE at cycle k gives:
  - updated ptr and GRANT=0 at k+1 (GAP);
  - IDLE at k+2;
  - earliest next CMD_REQ at k+3.
- RESET_N assertion mid-transaction returns all state to reset values immediately; the controller must be reset alongside.

## Configuration
- SCHED_RR_EN defined: round-robin selection.
  - The search starts at port (last_grant+1) mod 4.
  - last_grant updates at each IDLE→REQ transition.
- SCHED_RR_EN undefined: fixed priority 0 > 1 > 2 > 3 (reads ahead of writes); the last_grant register is absent.

## Test plan
- Load port 2 with start=0x100, max=0x300, len=128, then set level=128. Required: CMD_REQ at next cycle with CMD_WRITE=1, CMD_ADDR=0x100, CMD_LEN=128, GRANT=0100. After ACK/DONE, ptr becomes 0x180.
- Wrap: port 0 with start=0, max=256, len=128, level held 0, run 3 bursts. Required: CMD_ADDR sequence 0, 128, 0.
- All four ports continuously eligible, 8 transactions.
  - With SCHED_RR_EN: GRANT sequence 0001, 0010, 0100, 1000, repeating.
  - Without SCHED_RR_EN: GRANT always 0001.
- Assert P_LOAD[1] with start=0x40 while port 1 is in WAIT, then deliver CMD_DONE. Required: ptr1 = 0x40, not advanced; GRANT clears at DONE+1.
- Drop RESET_N while in WAIT. Required: CMD_REQ=0 and GRANT=0 asynchronously; after release, no request occurs until ports are reloaded.
- Port with len=0 at any level: required never granted.
